// File: rtl/lse_pkg.sv
// Shared LSE definitions: correction-table geometry, word type and loader FSM states.
// The loader's optional checksum beat is controlled by the LSE_CLUT_CHECKSUM_EN macro.
package lse_pkg;

    localparam int CLUT_SIZE      = 16;
    localparam int CLUT_ADDR_BITS = 4;
    localparam int CLUT_WORD_W    = 10;

    typedef logic [CLUT_WORD_W-1:0] clut_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        PEND  = 2'd3
    } clut_ld_state_e;

endpackage

// File: rtl/lse_clut_bank.sv
// Shadow/active CLUT register pair: indexed writes land in the shadow bank,
// and a swap copies the whole shadow bank into the active bank in one edge.
module lse_clut_bank
    import lse_pkg::*;
#(
    parameter int LUT_PRECISION = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [CLUT_ADDR_BITS-1:0] wr_addr,
    input  logic [LUT_PRECISION-1:0]  wr_data,
    input  logic                      swap,
    output logic [LUT_PRECISION-1:0]  active [0:CLUT_SIZE-1]
);

    logic [LUT_PRECISION-1:0] shadow [0:CLUT_SIZE-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CLUT_SIZE; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_en) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CLUT_SIZE; i++) begin
                active[i] <= '0;
            end
        end else if (swap) begin
            active <= shadow;
        end
    end

endmodule

// File: rtl/lse_clut_loader.sv
// CLUT writer for one LSE-PE cluster: streams 16 words into a shadow bank and swaps
// them into the active table when the PE is idle. Define LSE_CLUT_CHECKSUM_EN for the XOR check beat.
module lse_clut_loader
    import lse_pkg::*;
#(
    parameter int LUT_PRECISION = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     wr_valid,
    input  logic [LUT_PRECISION-1:0] wr_data,
    output logic                     wr_ready,
    input  logic                     swap_ok,
    output logic [LUT_PRECISION-1:0] clut_values [0:CLUT_SIZE-1],
    output logic                     busy,
    output logic                     load_done,
    output logic                     load_err
);

    clut_ld_state_e            state_q, state_d;
    logic [CLUT_ADDR_BITS-1:0] cnt_q, cnt_d;
    logic                      done_d, err_d;
    logic                      wr_en, swap, hs;
`ifdef LSE_CLUT_CHECKSUM_EN
    logic [LUT_PRECISION-1:0]  csum_q, csum_d;
`endif

    // Ready decodes registered state only, so there is no path from wr_valid.
    assign wr_ready = (state_q == LOAD) || (state_q == CHECK);
    assign busy     = (state_q != IDLE);
    assign hs       = wr_valid && wr_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        swap    = 1'b0;
`ifdef LSE_CLUT_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (load_start) begin
            // Restart wins over any beat or swap in the same cycle.
            state_d = LOAD;
            cnt_d   = '0;
            err_d   = (state_q != IDLE);
`ifdef LSE_CLUT_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (hs) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 1'b1;
`ifdef LSE_CLUT_CHECKSUM_EN
                        csum_d = csum_q ^ wr_data;
                        if (cnt_q == CLUT_ADDR_BITS'(CLUT_SIZE - 1)) state_d = CHECK;
`else
                        if (cnt_q == CLUT_ADDR_BITS'(CLUT_SIZE - 1)) state_d = PEND;
`endif
                    end
                end
`ifdef LSE_CLUT_CHECKSUM_EN
                CHECK: begin
                    if (hs) begin
                        if (wr_data == csum_q) begin
                            state_d = PEND;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
`endif
                PEND: begin
                    if (swap_ok) begin
                        swap    = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            load_done <= done_d;
            load_err  <= err_d;
        end
    end

`ifdef LSE_CLUT_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    lse_clut_bank #(
        .LUT_PRECISION(LUT_PRECISION)
    ) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_addr(cnt_q),
        .wr_data(wr_data),
        .swap   (swap),
        .active (clut_values)
    );

endmodule
